// File: rtl/ds_scan_if.sv
// Frame-buffer read-port bundle shared by the draw path and the downsample scan.
// The scheduler takes the master side; draw requesters and the filter take the slave side.
interface ds_scan_if #(
    parameter int AW = 17
);
    logic          draw_req_in;
    logic [AW-1:0] draw_addr_in;
    logic [AW-1:0] rd_addr_out;
    logic          rd_sel_out;
    logic [10:0]   hcount_ds_out;
    logic [9:0]    vcount_ds_out;
    logic          valid_ds_out;

    modport master (
        input  draw_req_in, draw_addr_in,
        output rd_addr_out, rd_sel_out, hcount_ds_out, vcount_ds_out, valid_ds_out
    );

    modport slave (
        output draw_req_in, draw_addr_in,
        input  rd_addr_out, rd_sel_out, hcount_ds_out, vcount_ds_out, valid_ds_out
    );
endinterface

// File: rtl/ds_scan_scheduler.sv
// Arbitrates the frame-buffer read port between draw (strict priority) and a once-per-frame
// band/column/sub-row downsample scan. Define DS_SCAN_STATS_EN to add stall_cycles_out.
module ds_scan_scheduler #(
    parameter int CAM_WIDTH    = 240,
    parameter int CAM_HEIGHT   = 320,
    parameter int FILTER_SIZE  = 5,
    parameter int TOTAL_LINES  = 750,
    parameter int TRIGGER_LINE = 700,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        enable_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    ds_scan_if.master   rd_if,
    output logic        busy_out,
    output logic        done_out,
    output logic        overrun_out
`ifdef DS_SCAN_STATS_EN
    ,
    output logic [15:0] stall_cycles_out
`endif
);

    localparam int AW = $clog2(CAM_WIDTH * CAM_HEIGHT);
    localparam int SW = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
    localparam int TRIG_LINE_C = (TRIGGER_LINE < TOTAL_LINES) ? TRIGGER_LINE : TOTAL_LINES - 1;
    // Moving from the bottom sub-row of one column to the top sub-row of the next column.
    localparam logic [AW-1:0] COL_BACK = AW'((FILTER_SIZE - 1) * CAM_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SCAN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [10:0]       col_q, col_d;
    logic [9:0]        row_q, row_d;
    logic [SW-1:0]     sub_q, sub_d;
    logic [AW-1:0]     saddr_q, saddr_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    logic              rd_sel_q, rd_sel_d;
    logic              iss_valid_q, iss_valid_d;
    logic [10:0]       iss_col_q, iss_col_d;
    logic [9:0]        iss_row_q, iss_row_d;
    logic [READ_LATENCY-1:0] pv_q, pv_d;
    logic [10:0]       ph_q [READ_LATENCY];
    logic [10:0]       ph_d [READ_LATENCY];
    logic [9:0]        pr_q [READ_LATENCY];
    logic [9:0]        pr_d [READ_LATENCY];
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;

    logic trig, fstart, last_pos, issue, flush, scan_start, draw;

    always_comb begin
        draw       = rd_if.draw_req_in;
        trig       = (vcount_in == 10'(TRIG_LINE_C)) && (hcount_in == '0);
        fstart     = (vcount_in == '0) && (hcount_in == '0);
        last_pos   = (row_q == 10'(CAM_HEIGHT - 1)) && (col_q == 11'(CAM_WIDTH - 1));
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        sub_d      = sub_q;
        saddr_d    = saddr_q;
        rd_addr_d  = draw ? rd_if.draw_addr_in : rd_addr_q;
        rd_sel_d   = 1'b0;
        iss_valid_d = 1'b0;
        iss_col_d  = iss_col_q;
        iss_row_d  = iss_row_q;
        overrun_d  = overrun_q;
        issue      = 1'b0;
        flush      = 1'b0;
        scan_start = 1'b0;

        case (state_q)
            S_IDLE:  if (enable_in) state_d = S_ARMED;
            S_ARMED: begin
                if (!enable_in) begin
                    state_d = S_IDLE;
                end else if (trig) begin
                    state_d    = S_SCAN;
                    scan_start = 1'b1;
                    col_d      = '0;
                    row_d      = '0;
                    sub_d      = '0;
                    saddr_d    = '0;
                end
            end
            S_SCAN: begin
                // Issuing the final address wins over a coincident frame start.
                if (!draw && last_pos) begin
                    issue   = 1'b1;
                    state_d = S_DONE;
                end else if (fstart) begin
                    state_d   = S_ARMED;
                    overrun_d = 1'b1;
                    flush     = 1'b1;
                end else if (!draw) begin
                    issue = 1'b1;
                end
            end
            S_DONE:  state_d = enable_in ? S_ARMED : S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            rd_addr_d   = saddr_q;
            rd_sel_d    = 1'b1;
            iss_valid_d = 1'b1;
            iss_col_d   = col_q;
            iss_row_d   = row_q;
            if (sub_q == SW'(FILTER_SIZE - 1)) begin
                sub_d = '0;
                if (col_q == 11'(CAM_WIDTH - 1)) begin
                    col_d   = '0;
                    row_d   = row_q + 10'd1;
                    saddr_d = saddr_q + AW'(1);
                end else begin
                    col_d   = col_q + 11'd1;
                    row_d   = row_q - 10'(FILTER_SIZE - 1);
                    saddr_d = saddr_q - COL_BACK;
                end
            end else begin
                sub_d   = sub_q + SW'(1);
                row_d   = row_q + 10'd1;
                saddr_d = saddr_q + AW'(CAM_WIDTH);
            end
        end

        pv_d[0] = iss_valid_q & ~flush;
        ph_d[0] = iss_col_q;
        pr_d[0] = iss_row_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pv_d[i] = pv_q[i-1] & ~flush;
            ph_d[i] = ph_q[i-1];
            pr_d[i] = pr_q[i-1];
        end

        busy_d = (state_d == S_SCAN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            sub_q       <= '0;
            saddr_q     <= '0;
            rd_addr_q   <= '0;
            rd_sel_q    <= 1'b0;
            iss_valid_q <= 1'b0;
            iss_col_q   <= '0;
            iss_row_q   <= '0;
            pv_q        <= '0;
            ph_q        <= '{default: '0};
            pr_q        <= '{default: '0};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            sub_q       <= sub_d;
            saddr_q     <= saddr_d;
            rd_addr_q   <= rd_addr_d;
            rd_sel_q    <= rd_sel_d;
            iss_valid_q <= iss_valid_d;
            iss_col_q   <= iss_col_d;
            iss_row_q   <= iss_row_d;
            pv_q        <= pv_d;
            ph_q        <= ph_d;
            pr_q        <= pr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rd_if.rd_addr_out   = rd_addr_q;
    assign rd_if.rd_sel_out    = rd_sel_q;
    assign rd_if.hcount_ds_out = ph_q[READ_LATENCY-1];
    assign rd_if.vcount_ds_out = pr_q[READ_LATENCY-1];
    assign rd_if.valid_ds_out  = pv_q[READ_LATENCY-1];
    assign busy_out            = busy_q;
    assign done_out            = done_q;
    assign overrun_out         = overrun_q;

`ifdef DS_SCAN_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (scan_start) begin
            stall_d = '0;
        end else if (state_q == S_SCAN && draw && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_cycles_out = stall_q;
`endif

endmodule

// File: tb/tb_ds_scan_scheduler.sv
// Directed + randomized bench for ds_scan_scheduler, checked against a frame-level model
// that derives the scan order and data timing from coordinates and arithmetic.
module tb_ds_scan_scheduler;
  localparam int W    = 4;
  localparam int H    = 10;
  localparam int FS   = 5;
  localparam int RL   = 2;
  localparam int TRIG = 700;
  localparam int AW   = $clog2(W * H);

  typedef enum int {M_IDLE, M_ARMED, M_SCAN, M_DONE} mode_t;
  typedef struct {
    int due;
    int col;
    int row;
  } pix_t;

  // clock / reset
  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        enable_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        busy_out;
  logic        done_out;
  logic        overrun_out;
`ifdef DS_SCAN_STATS_EN
  logic [15:0] stall_cycles_out;
`endif

  ds_scan_if #(.AW(AW)) bus ();

  ds_scan_scheduler #(
    .CAM_WIDTH(W), .CAM_HEIGHT(H), .FILTER_SIZE(FS), .TOTAL_LINES(750),
    .TRIGGER_LINE(TRIG), .READ_LATENCY(RL)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .enable_in(enable_in),
    .hcount_in(hcount_in),
    .vcount_in(vcount_in),
    .rd_if(bus.master),
    .busy_out(busy_out),
    .done_out(done_out),
    .overrun_out(overrun_out)
`ifdef DS_SCAN_STATS_EN
    ,
    .stall_cycles_out(stall_cycles_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  // scoreboard / model state
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  logic [AW-1:0] exp_q[$];
  pix_t          pix_q[$];
  mode_t         m_mode;
  bit            m_overrun;
  int            m_stall;
  int            trig_obs;
  int            first_valid;
  int            done_cnt;
  int            sel_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic fill_order();
    exp_q.delete();
    for (int b = 0; b < H / FS; b++)
      for (int c = 0; c < W; c++)
        for (int v = 0; v < FS; v++)
          exp_q.push_back(AW'((b * FS + v) * W + c));
  endtask

  task automatic model_reset();
    m_mode    = M_IDLE;
    m_overrun = 1'b0;
    m_stall   = 0;
    exp_q.delete();
    pix_q.delete();
  endtask

  task automatic set_neutral();
    vcount_in = 10'($urandom_range(1, 699));
    hcount_in = 11'($urandom_range(0, 2047));
  endtask

  task automatic check_all_zero(input string p);
    check({p, "_rd_addr"}, bus.rd_addr_out, 0);
    check({p, "_rd_sel"}, bus.rd_sel_out, 0);
    check({p, "_hcount_ds"}, bus.hcount_ds_out, 0);
    check({p, "_vcount_ds"}, bus.vcount_ds_out, 0);
    check({p, "_valid_ds"}, bus.valid_ds_out, 0);
    check({p, "_busy"}, busy_out, 0);
    check({p, "_done"}, done_out, 0);
    check({p, "_overrun"}, overrun_out, 0);
`ifdef DS_SCAN_STATS_EN
    check({p, "_stall"}, stall_cycles_out, 0);
`endif
  endtask

  // One clock: update the model from the inputs in force, clock, then compare at negedge.
  task automatic tick_check();
    bit            drq, trig, fs, exp_sel, exp_done, chk_addr, do_issue;
    logic [AW-1:0] exp_addr;
    logic [AW-1:0] a;
    pix_t          p;
    drq      = bus.draw_req_in;
    trig     = (vcount_in == 10'(TRIG)) && (hcount_in == 0);
    fs       = (vcount_in == 0) && (hcount_in == 0);
    exp_sel  = 1'b0;
    exp_done = 1'b0;
    do_issue = 1'b0;
    chk_addr = drq;
    exp_addr = bus.draw_addr_in;
    case (m_mode)
      M_IDLE:  if (enable_in) m_mode = M_ARMED;
      M_ARMED: begin
        if (!enable_in) m_mode = M_IDLE;
        else if (trig) begin
          m_mode      = M_SCAN;
          fill_order();
          m_stall     = 0;
          trig_obs    = cyc + 1;
          first_valid = -1;
        end
      end
      M_DONE:  m_mode = enable_in ? M_ARMED : M_IDLE;
      M_SCAN: begin
        if (drq && m_stall < 65535) m_stall++;
        if (!drq && exp_q.size() == 1) begin
          do_issue = 1'b1;
          m_mode   = M_DONE;
          exp_done = 1'b1;
        end else if (fs) begin
          m_mode    = M_ARMED;
          m_overrun = 1'b1;
          pix_q.delete();
          exp_q.delete();
        end else if (!drq) begin
          do_issue = 1'b1;
        end
      end
      default: m_mode = M_IDLE;
    endcase
    if (do_issue) begin
      a        = exp_q.pop_front();
      exp_sel  = 1'b1;
      chk_addr = 1'b1;
      exp_addr = a;
      pix_q.push_back('{cyc + 1 + RL, int'(a) % W, int'(a) / W});
    end

    @(posedge clk_in);
    @(negedge clk_in);
    cyc++;

    check("rd_sel", bus.rd_sel_out, exp_sel);
    if (chk_addr) check(exp_sel ? "scan_addr" : "draw_addr", bus.rd_addr_out, exp_addr);
    if (bus.rd_sel_out) sel_cnt++;
    if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
      p = pix_q.pop_front();
      check("valid_ds", bus.valid_ds_out, 1);
      check("hcount_ds", bus.hcount_ds_out, p.col);
      check("vcount_ds", bus.vcount_ds_out, p.row);
    end else begin
      check("valid_ds_idle", bus.valid_ds_out, 0);
    end
    if (bus.valid_ds_out && first_valid < 0) first_valid = cyc;
    check("busy", busy_out, (m_mode == M_SCAN));
    check("done", done_out, exp_done);
    check("overrun", overrun_out, m_overrun);
    if (done_out) done_cnt++;
`ifdef DS_SCAN_STATS_EN
    check("stall_cycles", stall_cycles_out, m_stall);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_neutral();
      bus.draw_req_in = 1'b0;
      tick_check();
    end
  endtask

  task automatic do_trigger();
    vcount_in       = 10'(TRIG);
    hcount_in       = 11'd0;
    bus.draw_req_in = 1'b0;
    tick_check();
    set_neutral();
  endtask

  // dmode: 0 no draw, 1 random draw, 2 draw on scan cycles 3..7
  task automatic run_scan(input int dmode, input int max_ticks);
    int k;
    k = 0;
    while (m_mode == M_SCAN && k < max_ticks) begin
      k++;
      set_neutral();
      case (dmode)
        1:       bus.draw_req_in = ($urandom_range(0, 99) < 30);
        2:       bus.draw_req_in = (k >= 3 && k <= 7);
        default: bus.draw_req_in = 1'b0;
      endcase
      bus.draw_addr_in = AW'($urandom_range(0, (1 << AW) - 1));
      tick_check();
    end
    bus.draw_req_in = 1'b0;
    check("scan_ended_busy", busy_out, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_in           = 1'b1;
    enable_in        = 1'b0;
    bus.draw_req_in  = 1'b0;
    bus.draw_addr_in = '0;
    set_neutral();
    model_reset();
    done_cnt    = 0;
    sel_cnt     = 0;
    first_valid = -1;
    trig_obs    = 0;
    repeat (3) @(negedge clk_in);
    check_all_zero("reset");
    rst_in = 1'b0;

    // T1: plain scan, order, first-valid latency, one done pulse
    enable_in = 1'b1;
    idle(3);
    sel_cnt  = 0;
    done_cnt = 0;
    do_trigger();
    run_scan(0, 200);
    idle(4);
    check("t1_issue_count", sel_cnt, 40);
    check("t1_done_count", done_cnt, 1);
    check("t1_first_valid_lat", first_valid - trig_obs, 3);

    // T2: draw window on scan cycles 3..7
    sel_cnt  = 0;
    done_cnt = 0;
    do_trigger();
    run_scan(2, 200);
    idle(3);
    check("t2_issue_count", sel_cnt, 40);
    check("t2_done_count", done_cnt, 1);
`ifdef DS_SCAN_STATS_EN
    check("t2_stall_count", stall_cycles_out, 5);
`endif

    // T4: last issue coincides with frame start
    done_cnt = 0;
    do_trigger();
    for (int i = 1; i <= 40; i++) begin
      set_neutral();
      bus.draw_req_in = 1'b0;
      if (i == 40) begin
        vcount_in = 10'd0;
        hcount_in = 11'd0;
      end
      tick_check();
    end
    check("t4_done_pulse", done_out, 1);
    check("t4_overrun", overrun_out, 0);
    idle(3);
    check("t4_done_count", done_cnt, 1);

    // T6: disable before trigger, then drop enable mid-scan
    enable_in = 1'b0;
    idle(3);
    sel_cnt = 0;
    do_trigger();
    idle(2);
    check("t6_no_scan_busy", busy_out, 0);
    check("t6_no_scan_issues", sel_cnt, 0);
    enable_in = 1'b1;
    idle(2);
    done_cnt = 0;
    do_trigger();
    idle(10);
    enable_in = 1'b0;
    run_scan(1, 300);
    idle(4);
    check("t6_finished_after_disable", done_cnt, 1);
    check("t6_issue_count", sel_cnt, 40);
    do_trigger();
    idle(3);
    check("t6_idle_no_rescan", sel_cnt, 40);

    // randomized scans with random draw traffic
    enable_in = 1'b1;
    idle(2);
    for (int s = 0; s < 4; s++) begin
      do_trigger();
      run_scan(1, 400);
      idle($urandom_range(1, 5));
    end

    // T3: draw starves the scan until frame start, then a fresh scan
    done_cnt = 0;
    do_trigger();
    idle(10);
    for (int i = 0; i < 20; i++) begin
      set_neutral();
      bus.draw_req_in  = 1'b1;
      bus.draw_addr_in = AW'($urandom_range(0, (1 << AW) - 1));
      tick_check();
    end
    vcount_in       = 10'd0;
    hcount_in       = 11'd0;
    bus.draw_req_in = 1'b1;
    tick_check();
    bus.draw_req_in = 1'b0;
    idle(4);
    check("t3_overrun", overrun_out, 1);
    check("t3_no_done", done_cnt, 0);
    check("t3_valid_flushed", bus.valid_ds_out, 0);
    do_trigger();
    idle(1);
    check("t3_restart_sel", bus.rd_sel_out, 1);
    check("t3_restart_addr", bus.rd_addr_out, 0);
    run_scan(1, 400);
    idle(3);

    // T5: asynchronous reset mid-scan at address 17
    do_trigger();
    k = 0;
    while (!(bus.rd_sel_out && bus.rd_addr_out == AW'(17)) && k < 100) begin
      k++;
      idle(1);
    end
    check("t5_reach_17", bus.rd_addr_out, 17);
    rst_in = 1'b1;
    #1;
    check_all_zero("t5_async_reset");
    model_reset();
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    idle(6);
    check("t5_post_reset_valid", bus.valid_ds_out, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
